// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and the decimal overflow limit helper.
package bin_to_bcd_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic longint unsigned bcd_limit(input int unsigned digits);
        longint unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adjust.sv
// Single-digit double-dabble correction: adds 3 when the digit is 5 or more.
// Purely combinational; one instance per BCD digit.
module bcd_digit_adjust
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), one iteration per clock.
// The registered result only updates on the done edge, so the display never sees partial values.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int              BCD_W = 4 * DIGITS;
    localparam int              CNT_W = $clog2(BIN_W) + 1;
    localparam int              SR_W  = BCD_W + 1 + BIN_W;
    localparam longint unsigned LIMIT = bcd_limit(DIGITS);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    // {bcd_work[BCD_W:0], bin_shift[BIN_W-1:0]} kept as one shift register
    logic [SR_W-1:0]    shift_q, shift_n;
    logic               ovf_lat, ovf_lat_n;
    logic               busy_n, done_n, ovf_n;
    logic [BCD_W-1:0]   bcd_n;
    logic [BCD_W:0]     adj;
    logic               last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adj (
            .digit_in  (shift_q[BIN_W + 4*g +: 4]),
            .digit_out (adj[4*g +: 4])
        );
    end
    // Carry bit is not corrected, only shifted out and dropped.
    assign adj[BCD_W] = shift_q[SR_W-1];

    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            shift_q <= '0;
            ovf_lat <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift_q <= shift_n;
            ovf_lat <= ovf_lat_n;
            busy    <= busy_n;
            done    <= done_n;
            bcd     <= bcd_n;
            ovf     <= ovf_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift_q;
        ovf_lat_n = ovf_lat;
        busy_n    = busy;
        done_n    = 1'b0;
        bcd_n     = bcd;
        ovf_n     = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    shift_n   = {{(BCD_W + 1){1'b0}}, bin};
                    ovf_lat_n = (64'(bin) > LIMIT);
                    cnt_n     = '0;
                    busy_n    = 1'b1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                shift_n = {adj, shift_q[BIN_W-1:0]} << 1;
                cnt_n   = cnt + 1'b1;
                if (last_iter) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    ovf_n   = ovf_lat;
                    bcd_n   = ovf_lat ? {DIGITS{4'h9}} : shift_n[BIN_W +: BCD_W];
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: hand-computed BCD results, overflow,
// ignored starts, back-to-back conversions and asynchronous reset mid-run.
module tb_bin_to_bcd_seq;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [7:0] bcd;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full conversion: busy length, result, hold of previous result, one-cycle done.
    task automatic convert(input logic [7:0] b, input logic [7:0] exp_bcd, input logic exp_ovf,
                           input logic [7:0] prev_bcd);
        int n;
        n = 0;
        bin   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 8'hA5;
        while (busy && n < 20) begin
            n++;
            if (n == 4) begin
                check_eq($sformatf("hold_bcd[%0d]", b), 32'(bcd), 32'(prev_bcd));
                check_eq($sformatf("hold_done[%0d]", b), 32'(done), 0);
            end
            tick();
        end
        check_eq($sformatf("busy_cycles[%0d]", b), n, 8);
        check_eq($sformatf("done[%0d]", b), 32'(done), 1);
        check_eq($sformatf("bcd[%0d]", b), 32'(bcd), 32'(exp_bcd));
        check_eq($sformatf("ovf[%0d]", b), 32'(ovf), 32'(exp_ovf));
        tick();
        check_eq($sformatf("done_clear[%0d]", b), 32'(done), 0);
        check_eq($sformatf("bcd_keep[%0d]", b), 32'(bcd), 32'(exp_bcd));
    endtask

    initial begin
        int ndone;
        int gap;
        resetn = 1'b0;
        start  = 1'b0;
        bin    = 8'd0;
        repeat (2) tick();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_bcd", 32'(bcd), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        resetn = 1'b1;
        tick();

        convert(8'd0,   8'h00, 1'b0, 8'h00);
        convert(8'd42,  8'h42, 1'b0, 8'h00);
        convert(8'd99,  8'h99, 1'b0, 8'h42);
        convert(8'd200, 8'h99, 1'b1, 8'h99);
        convert(8'd7,   8'h07, 1'b0, 8'h99);
        convert(8'd100, 8'h99, 1'b1, 8'h07);
        convert(8'd255, 8'h99, 1'b1, 8'h99);

        // start during busy (cycles 2-5) must be ignored
        bin   = 8'd55;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        bin   = 8'd10;
        repeat (4) tick();
        start = 1'b0;
        ndone = 0;
        repeat (20) begin
            tick();
            if (done) ndone++;
        end
        check_eq("ign_done_count", ndone, 1);
        check_eq("ign_bcd", 32'(bcd), 32'h55);
        check_eq("ign_ovf", 32'(ovf), 0);
        check_eq("ign_busy", 32'(busy), 0);

        // back-to-back: start accepted in the done cycle
        bin   = 8'd37;
        start = 1'b1;
        tick();
        start = 1'b0;
        gap = 0;
        while (!done && gap < 20) begin
            tick();
            gap++;
        end
        check_eq("b2b_first_done", 32'(done), 1);
        check_eq("b2b_first_bcd", 32'(bcd), 32'h37);
        start = 1'b1;
        bin   = 8'd81;
        gap = 0;
        do begin
            tick();
            gap++;
            if (gap == 1) begin
                start = 1'b0;
                check_eq("b2b_busy", 32'(busy), 1);
            end
        end while (!done && gap < 20);
        // accept edge one after first done, then 8 iterations
        check_eq("b2b_gap", gap, 9);
        check_eq("b2b_second_bcd", 32'(bcd), 32'h81);
        tick();

        // asynchronous reset mid-conversion
        bin   = 8'd63;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_eq("mid_busy", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_bcd", 32'(bcd), 0);
        check_eq("arst_ovf", 32'(ovf), 0);
        check_eq("arst_done", 32'(done), 0);
        ndone = 0;
        repeat (2) begin
            tick();
            if (done) ndone++;
        end
        resetn = 1'b1;
        repeat (12) begin
            tick();
            if (done) ndone++;
        end
        check_eq("arst_no_done", ndone, 0);
        check_eq("arst_bcd_after", 32'(bcd), 0);
        check_eq("arst_busy_after", 32'(busy), 0);

        convert(8'd63, 8'h63, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
